// File: rtl/uart_rx_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_engine_if
//  Description : Read-side bundle between the UART receive engine and the
//                APB register block: FIFO pop, interrupt clears, FIFO head,
//                occupancy and interrupt flags.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_engine_if #(
    parameter int CNT_W = 3
);
    logic             rd_en;
    logic [2:0]       int_clr;
    logic [7:0]       rx_data;
    logic             rx_empty;
    logic             rx_full;
    logic [CNT_W-1:0] rx_count;
    logic             ctrl_rif;
    logic             ctrl_pif;
    logic             ctrl_fif;
    logic             ctrl_oif;

    // Register block side: pops and clears, observes data and flags
    modport master (
        output rd_en, int_clr,
        input  rx_data, rx_empty, rx_full, rx_count,
               ctrl_rif, ctrl_pif, ctrl_fif, ctrl_oif
    );

    // Receive engine side
    modport slave (
        input  rd_en, int_clr,
        output rx_data, rx_empty, rx_full, rx_count,
               ctrl_rif, ctrl_pif, ctrl_fif, ctrl_oif
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_engine
//  Description : UART receive path. Two-flop synchroniser, 16x oversampled
//                start detection, 5-8 data bits, optional parity, 1/2 stop
//                bits, small show-ahead receive FIFO and sticky error flags.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_engine #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  wire              pclk,
    input  wire              preset,
    input  wire [DIV_W-1:0]  baud_div,
    input  wire [1:0]        cfg_data_bits,
    input  wire              cfg_parity_en,
    input  wire              cfg_parity_odd,
    input  wire              cfg_stop2,
    input  wire              uart_rx,
    uart_rx_engine_if.slave  rd_if
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_WAITHI = 3'd5
    } state_t;

    logic               rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    state_t             state_q, state_d;
    logic [3:0]         sc_q, sc_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         data_q, data_d;
    logic [1:0]         nbits_q, nbits_d;
    logic               par_en_q, par_en_d, par_odd_q, par_odd_d;
    logic               stop2_q, stop2_d, stop_idx_q, stop_idx_d;
    logic               perr_q, perr_d, ferr_q, ferr_d;
    logic               push_q, push_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [7:0]         mem_d [FIFO_DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic               pif_q, pif_d, fif_q, fif_d, oif_q, oif_d;

    logic w_tick, w_last_bit, w_empty, w_full, w_pop, w_push, w_drop;

    // Synchroniser chain and oversample tick divider
    always_comb begin
        rx_meta_d  = uart_rx;
        rx_s_d     = rx_meta_q;
        // >= keeps the divider bounded if baud_div is lowered while running
        w_tick     = (div_cnt_q >= baud_div);
        div_cnt_d  = w_tick ? '0 : div_cnt_q + 1'b1;
    end

    // Frame FSM: start validation, bit sampling at sc==15, frame completion
    always_comb begin
        state_d    = state_q;
        sc_d       = sc_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        push_d     = 1'b0;
        w_last_bit = (bit_cnt_q == ({1'b0, nbits_q} + 3'd4));
        case (state_q)
            S_IDLE: begin
                if (w_tick && !rx_s_q) begin
                    state_d    = S_START;
                    sc_d       = '0;
                    bit_cnt_d  = '0;
                    data_d     = '0;
                    nbits_d    = cfg_data_bits;
                    par_en_d   = cfg_parity_en;
                    par_odd_d  = cfg_parity_odd;
                    stop2_d    = cfg_stop2;
                    stop_idx_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (sc_q == 4'd7) begin
                        sc_d    = '0;
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    sc_d = sc_q + 4'd1;
                    if (sc_q == 4'd15) begin
                        data_d[bit_cnt_q] = rx_s_q;
                        bit_cnt_d         = bit_cnt_q + 3'd1;
                        if (w_last_bit) begin
                            state_d = par_en_q ? S_PARITY : S_STOP;
                        end
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    sc_d = sc_q + 4'd1;
                    if (sc_q == 4'd15) begin
                        if (rx_s_q != ((^data_q) ^ par_odd_q)) begin
                            perr_d = 1'b1;
                        end
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    sc_d = sc_q + 4'd1;
                    if (sc_q == 4'd15) begin
                        if (!rx_s_q) begin
                            ferr_d = 1'b1;
                        end
                        if (stop2_q && !stop_idx_q && rx_s_q) begin
                            stop_idx_d = 1'b1;
                        end else begin
                            push_d  = 1'b1;
                            // A low stop bit may be a break; wait for idle first
                            state_d = rx_s_q ? S_IDLE : S_WAITHI;
                        end
                    end
                end
            end
            S_WAITHI: begin
                if (w_tick && rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Receive FIFO and sticky interrupt flags
    always_comb begin
        w_empty  = (count_q == '0);
        w_full   = (count_q == c_CNT_W'(FIFO_DEPTH));
        w_pop    = rd_if.rd_en && !w_empty;
        w_push   = push_q && (!w_full || w_pop);
        w_drop   = push_q && w_full && !w_pop;
        mem_d    = mem_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = data_q;
        end
        wr_ptr_d = wr_ptr_q + c_PTR_W'(w_push);
        rd_ptr_d = rd_ptr_q + c_PTR_W'(w_pop);
        count_d  = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 1'b1;
        end
        pif_d = (pif_q && !rd_if.int_clr[0]) || (push_q && perr_q);
        fif_d = (fif_q && !rd_if.int_clr[1]) || (push_q && ferr_q);
        oif_d = (oif_q && !rd_if.int_clr[2]) || w_drop;
    end

    // State registers
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            div_cnt_q  <= '0;
            state_q    <= S_IDLE;
            sc_q       <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            nbits_q    <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            push_q     <= 1'b0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pif_q      <= 1'b0;
            fif_q      <= 1'b0;
            oif_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            div_cnt_q  <= div_cnt_d;
            state_q    <= state_d;
            sc_q       <= sc_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            push_q     <= push_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pif_q      <= pif_d;
            fif_q      <= fif_d;
            oif_q      <= oif_d;
        end
    end

    // Read-side outputs; rx_data is the show-ahead head entry
    always_comb begin
        rd_if.rx_data  = mem_q[rd_ptr_q];
        rd_if.rx_empty = w_empty;
        rd_if.rx_full  = w_full;
        rd_if.rx_count = count_q;
        rd_if.ctrl_rif = !w_empty;
        rd_if.ctrl_pif = pif_q;
        rd_if.ctrl_fif = fif_q;
        rd_if.ctrl_oif = oif_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_engine
//  Description : Self-checking bench for uart_rx_engine: directed scenarios
//                plus randomized frames checked through a scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_engine;

    localparam int FIFO_DEPTH = 4;
    localparam int DIV_W      = 16;

    logic             pclk           = 1'b0;
    logic             preset         = 1'b1;
    logic [DIV_W-1:0] baud_div       = 16'd3;
    logic [1:0]       cfg_data_bits  = 2'b11;
    logic             cfg_parity_en  = 1'b0;
    logic             cfg_parity_odd = 1'b0;
    logic             cfg_stop2      = 1'b0;
    logic             uart_rx        = 1'b1;

    logic       rd_main  = 1'b0;
    logic       rd_mon   = 1'b0;
    logic [2:0] clr_main = 3'b000;
    logic [2:0] clr_mon  = 3'b000;
    bit         auto_read = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;
    exp_t exp_q[$];

    uart_rx_engine_if #(.CNT_W(3)) rd_bus ();

    assign rd_bus.rd_en   = rd_main | rd_mon;
    assign rd_bus.int_clr = clr_main | clr_mon;

    uart_rx_engine #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
        .pclk           (pclk),
        .preset         (preset),
        .baud_div       (baud_div),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .uart_rx        (uart_rx),
        .rd_if          (rd_bus)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic int bitc();
        return 16 * (int'(baud_div) + 1);
    endfunction

    task automatic drive_bit(input logic b);
        uart_rx = b;
        repeat (bitc()) @(negedge pclk);
    endtask

    // Serialise one frame; cfg inputs are scrambled after the start bit
    task automatic send_frame(input logic [7:0] d, input logic [1:0] nb, input logic pe,
                              input logic po, input logic s2, input logic bp,
                              input logic bs1, input logic bs2);
        int   n;
        logic par;
        n = int'(nb) + 5;
        cfg_data_bits  = nb;
        cfg_parity_en  = pe;
        cfg_parity_odd = po;
        cfg_stop2      = s2;
        @(negedge pclk);
        drive_bit(1'b0);
        cfg_data_bits  = 2'($urandom_range(3, 0));
        cfg_parity_en  = 1'($urandom_range(1, 0));
        cfg_parity_odd = 1'($urandom_range(1, 0));
        cfg_stop2      = 1'($urandom_range(1, 0));
        par = po ^ bp;
        for (int i = 0; i < n; i++) begin
            drive_bit(d[i]);
            par = par ^ d[i];
        end
        if (pe) drive_bit(par);
        drive_bit(!bs1);
        if (s2) drive_bit(!bs2);
        drive_bit(1'b1);
    endtask

    task automatic wait_count(input logic [2:0] want, input string name);
        for (int i = 0; i < 4000; i++) begin
            if (rd_bus.rx_count == want) break;
            @(negedge pclk);
        end
        check(name, rd_bus.rx_count, want);
    endtask

    task automatic pop();
        rd_main = 1'b1;
        @(negedge pclk);
        rd_main = 1'b0;
    endtask

    task automatic clr(input logic [2:0] v);
        clr_main = v;
        @(negedge pclk);
        clr_main = 3'b000;
    endtask

    task automatic set_8n1();
        cfg_data_bits  = 2'b11;
        cfg_parity_en  = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_stop2      = 1'b0;
    endtask

    // Scoreboard monitor: checks and pops each frame the DUT presents
    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            rd_mon  = 1'b0;
            clr_mon = 3'b000;
            if (auto_read && !rd_bus.rx_empty) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got %0h expected none", rd_bus.rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", rd_bus.rx_data, e.data);
                    check("sb_perr", rd_bus.ctrl_pif, e.perr);
                    check("sb_ferr", rd_bus.ctrl_fif, e.ferr);
                end
                rd_mon  = 1'b1;
                clr_mon = 3'b011;
            end
        end
    end

    // Global time bound
    initial begin
        #5000000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [7:0] d;
        logic [1:0] nb;
        logic       pe, po, s2, bp, bs1, bs2;
        exp_t       e;

        // Reset state
        repeat (3) @(negedge pclk);
        check("rst_data",  rd_bus.rx_data, 8'h00);
        check("rst_empty", rd_bus.rx_empty, 1'b1);
        check("rst_full",  rd_bus.rx_full, 1'b0);
        check("rst_count", rd_bus.rx_count, 3'd0);
        check("rst_flags", {rd_bus.ctrl_rif, rd_bus.ctrl_pif, rd_bus.ctrl_fif, rd_bus.ctrl_oif}, 4'b0000);
        preset = 1'b0;
        repeat (5) @(negedge pclk);

        // 8N1 0xA5
        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_count(3'd1, "a5_count");
        check("a5_data", rd_bus.rx_data, 8'hA5);
        check("a5_rif",  rd_bus.ctrl_rif, 1'b1);
        check("a5_errs", {rd_bus.ctrl_pif, rd_bus.ctrl_fif, rd_bus.ctrl_oif}, 3'b000);
        pop();
        check("a5_empty", rd_bus.rx_empty, 1'b1);

        // 7 bits even parity, wrong parity bit
        send_frame(8'h35, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_count(3'd1, "par_count");
        check("par_data", rd_bus.rx_data, 8'h35);
        check("par_pif",  rd_bus.ctrl_pif, 1'b1);
        check("par_fif",  rd_bus.ctrl_fif, 1'b0);
        clr(3'b001);
        check("par_clr",  rd_bus.ctrl_pif, 1'b0);
        pop();

        // Start glitch of 4 ticks
        set_8n1();
        uart_rx = 1'b0;
        repeat (4 * (int'(baud_div) + 1)) @(negedge pclk);
        uart_rx = 1'b1;
        repeat (2 * bitc()) @(negedge pclk);
        check("glitch_count", rd_bus.rx_count, 3'd0);
        check("glitch_empty", rd_bus.rx_empty, 1'b1);

        // Break: line low 20 bit times
        set_8n1();
        uart_rx = 1'b0;
        repeat (20 * bitc()) @(negedge pclk);
        check("brk_count", rd_bus.rx_count, 3'd1);
        check("brk_data",  rd_bus.rx_data, 8'h00);
        check("brk_fif",   rd_bus.ctrl_fif, 1'b1);
        uart_rx = 1'b1;
        repeat (2 * bitc()) @(negedge pclk);
        check("brk_count_hi", rd_bus.rx_count, 3'd1);
        pop();
        clr(3'b010);
        check("brk_clr", rd_bus.ctrl_fif, 1'b0);

        // Overrun: five frames into a four-entry FIFO
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("ovr_full",  rd_bus.rx_full, 1'b1);
        check("ovr_oif",   rd_bus.ctrl_oif, 1'b1);
        check("ovr_count", rd_bus.rx_count, 3'd4);
        for (int k = 1; k <= 4; k++) begin
            check("ovr_data", rd_bus.rx_data, 32'(k));
            pop();
        end
        check("ovr_empty", rd_bus.rx_empty, 1'b1);
        clr(3'b100);
        check("ovr_clr", rd_bus.ctrl_oif, 1'b0);

        // Reset in the middle of an 8N2 frame
        send_frame(8'h77, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_count(3'd1, "mid_pre_count");
        fork
            send_frame(8'hFF, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            begin
                repeat (3 * bitc()) @(negedge pclk);
                #2 preset = 1'b1;
                #3;
                check("mid_rst_count", rd_bus.rx_count, 3'd0);
                check("mid_rst_empty", rd_bus.rx_empty, 1'b1);
                check("mid_rst_data",  rd_bus.rx_data, 8'h00);
                check("mid_rst_flags", {rd_bus.rx_full, rd_bus.ctrl_rif, rd_bus.ctrl_pif,
                                        rd_bus.ctrl_fif, rd_bus.ctrl_oif}, 5'b00000);
                #17 preset = 1'b0;
            end
        join
        check("mid_post_count", rd_bus.rx_count, 3'd0);
        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_count(3'd1, "mid_3c_count");
        check("mid_3c_data", rd_bus.rx_data, 8'h3C);
        check("mid_3c_errs", {rd_bus.ctrl_pif, rd_bus.ctrl_fif}, 2'b00);
        pop();

        // Randomized frames through the scoreboard at a faster baud rate
        @(negedge pclk);
        preset   = 1'b1;
        baud_div = 16'd1;
        repeat (3) @(negedge pclk);
        preset    = 1'b0;
        auto_read = 1'b1;
        repeat (4) @(negedge pclk);
        for (int f = 0; f < 30; f++) begin
            d   = 8'($urandom);
            nb  = 2'($urandom_range(3, 0));
            pe  = 1'($urandom_range(1, 0));
            po  = 1'($urandom_range(1, 0));
            s2  = 1'($urandom_range(1, 0));
            bp  = ($urandom_range(4, 0) == 0);
            bs1 = ($urandom_range(5, 0) == 0);
            bs2 = ($urandom_range(5, 0) == 0);
            e.data = d & 8'((1 << (int'(nb) + 5)) - 1);
            e.perr = pe & bp;
            e.ferr = bs1 | (s2 & bs2);
            exp_q.push_back(e);
            send_frame(d, nb, pe, po, s2, bp, bs1, bs2);
        end
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge pclk);
        end
        check("sb_drain", exp_q.size(), 0);
        repeat (4) @(negedge pclk);
        check("sb_final_empty", rd_bus.rx_empty, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
